lstm_seq_ctrl: RTL and testbench
================================

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width of every address output.
REQ-002 SHALL have parameter TIMESTEP, default 7, timesteps per run.
REQ-003 SHALL have parameters LAYR1_INPUT (53), LAYR1_CELL (53) and LAYR2_CELL (8): layer-1 input length, layer-1 cell count and layer-2 cell count.
REQ-004 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports start (in, 1, run request) and en (in, 1, stall when 0).
REQ-006 SHALL have outputs busy (1), done (1), t_idx (ADDR_W) and cell_idx (ADDR_W).
REQ-007 SHALL have layer-1 outputs acc_x_1, acc_h_1, wr_h1, wr_c1, clr_1 (1 each).
REQ-008 SHALL have layer-1 address outputs addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1, wr_addr_h1, wr_addr_c1 (ADDR_W each).
REQ-009 SHALL have layer-2 outputs acc_x_2, acc_h_2, wr_h2, wr_c2, clr_2 (1 each).
REQ-010 SHALL have layer-2 address outputs rd_addr_x2, rd_addr_w_2, rd_addr_u_2, rd_addr_b_2, rd_addr_h2, rd_addr_c2, wr_addr_h2, wr_addr_c2 (ADDR_W each).

Function
REQ-011 SHALL implement states IDLE, L1_ACC, L1_DRAIN, L1_WR, L1_CLR, L2_ACC, L2_DRAIN, L2_WR, L2_CLR, DONE.
REQ-012 SHALL move IDLE->L1_ACC on the edge where start=1; start SHALL be ignored outside IDLE.
REQ-013 SHALL define N1=max(LAYR1_INPUT,LAYR1_CELL) and N2=max(LAYR1_CELL,LAYR2_CELL); counter k runs 0..N-1 in each ACC state.
REQ-014 SHALL sequence each cell as ACC (N cycles) -> DRAIN (1) -> WR (1) -> CLR (1), then the next cell.
REQ-015 SHALL go from L1_CLR of the last layer-1 cell to L2_ACC cell 0.
REQ-016 SHALL go from L2_CLR of the last layer-2 cell to L1_ACC of timestep t+1, or to DONE when t=TIMESTEP-1.
REQ-017 SHALL go from DONE to IDLE after 1 cycle.
REQ-018 In L1_ACC: acc_x_1=(k<LAYR1_INPUT); acc_h_1=(k<LAYR1_CELL and t>0); at t=0 acc_h_1 SHALL stay 0 (zero initial h).
REQ-019 In L1_ACC: addr_x1=t*LAYR1_INPUT+k, rd_addr_w_1=j*LAYR1_INPUT+k, rd_addr_u_1=j*LAYR1_CELL+k, rd_addr_h1=(t-1)*LAYR1_CELL+k (0 at t=0).
REQ-020 In L2_ACC: acc_x_2=(k<LAYR1_CELL); acc_h_2=(k<LAYR2_CELL and t>0).
REQ-021 In L2_ACC: rd_addr_x2=t*LAYR1_CELL+k, rd_addr_w_2=j*LAYR1_CELL+k, rd_addr_u_2=j*LAYR2_CELL+k, rd_addr_h2=(t-1)*LAYR2_CELL+k (0 at t=0).
REQ-022 For the whole cell: rd_addr_b_n=j; rd_addr_cn=(t-1)*CELLn+j (0 at t=0).
REQ-023 WR states SHALL pulse wr_hn and wr_cn for 1 cycle at wr_addr_hn=wr_addr_cn=t*CELLn+j.
REQ-024 CLR states SHALL pulse clr_n for 1 cycle; DRAIN SHALL assert no strobe.
REQ-025 All strobe and write outputs SHALL be registered and 0 outside their states.
REQ-026 en=0 SHALL freeze state, counters and addresses, and force every acc/wr/clr strobe to 0; resume on en=1 with no lost or repeated cycle.
REQ-027 busy=1 in all states except IDLE; done=1 only in DONE; t_idx=t, cell_idx=j.
REQ-028 Address arithmetic SHALL be unsigned modulo 2^ADDR_W.
REQ-029 Total cycles start->done SHALL be TIMESTEP*(LAYR1_CELL*(N1+3)+LAYR2_CELL*(N2+3))+1 with en held 1 (defaults: 23913).

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, all counters 0 and every output 0, including mid-run.
REQ-031 After rst release the block SHALL need a fresh start pulse; no run resumes.

Verification
REQ-032 Params TIMESTEP=2, LAYR1_INPUT=3, LAYR1_CELL=2, LAYR2_CELL=1; start at cycle 0 -> done high at cycle 35 only, busy cycles 1..35.
REQ-033 Same params, t=0 -> acc_h_1 and acc_h_2 never 1; t=1 -> acc_h_1 high 2 cycles per layer-1 cell, rd_addr_h1 0,1.
REQ-034 Same params -> wr_h1 addresses 0,1,2,3 in order, wr_h2 addresses 0,1, each a 1-cycle pulse followed next cycle by clr.
REQ-035 en=0 for 5 cycles mid-L1_ACC -> outputs frozen, strobes 0, done delayed exactly 5 cycles.
REQ-036 rst asserted in L2_ACC -> same-cycle IDLE, all outputs 0; start pulse during busy is ignored and the cycle count is unchanged.

Source files
------------

// File: rtl/lstm_seq_ctrl.sv
// Two-layer LSTM sequencer: walks timesteps, cells and the MAC index k,
// issuing registered accumulate/write/clear strobes and memory addresses.
module lstm_seq_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int TIMESTEP    = 7,
    parameter int LAYR1_INPUT = 53,
    parameter int LAYR1_CELL  = 53,
    parameter int LAYR2_CELL  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] t_idx,
    output logic [ADDR_W-1:0] cell_idx,
    output logic              acc_x_1,
    output logic              acc_h_1,
    output logic              wr_h1,
    output logic              wr_c1,
    output logic              clr_1,
    output logic [ADDR_W-1:0] addr_x1,
    output logic [ADDR_W-1:0] rd_addr_w_1,
    output logic [ADDR_W-1:0] rd_addr_u_1,
    output logic [ADDR_W-1:0] rd_addr_b_1,
    output logic [ADDR_W-1:0] rd_addr_h1,
    output logic [ADDR_W-1:0] rd_addr_c1,
    output logic [ADDR_W-1:0] wr_addr_h1,
    output logic [ADDR_W-1:0] wr_addr_c1,
    output logic              acc_x_2,
    output logic              acc_h_2,
    output logic              wr_h2,
    output logic              wr_c2,
    output logic              clr_2,
    output logic [ADDR_W-1:0] rd_addr_x2,
    output logic [ADDR_W-1:0] rd_addr_w_2,
    output logic [ADDR_W-1:0] rd_addr_u_2,
    output logic [ADDR_W-1:0] rd_addr_b_2,
    output logic [ADDR_W-1:0] rd_addr_h2,
    output logic [ADDR_W-1:0] rd_addr_c2,
    output logic [ADDR_W-1:0] wr_addr_h2,
    output logic [ADDR_W-1:0] wr_addr_c2
);

    localparam int N1 = (LAYR1_INPUT > LAYR1_CELL) ? LAYR1_INPUT : LAYR1_CELL;
    localparam int N2 = (LAYR1_CELL > LAYR2_CELL) ? LAYR1_CELL : LAYR2_CELL;

    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] L1I_A    = ADDR_W'(LAYR1_INPUT);
    localparam logic [ADDR_W-1:0] L1C_A    = ADDR_W'(LAYR1_CELL);
    localparam logic [ADDR_W-1:0] L2C_A    = ADDR_W'(LAYR2_CELL);
    localparam logic [ADDR_W-1:0] N1_LAST  = ADDR_W'(N1 - 1);
    localparam logic [ADDR_W-1:0] N2_LAST  = ADDR_W'(N2 - 1);
    localparam logic [ADDR_W-1:0] L1C_LAST = ADDR_W'(LAYR1_CELL - 1);
    localparam logic [ADDR_W-1:0] L2C_LAST = ADDR_W'(LAYR2_CELL - 1);
    localparam logic [ADDR_W-1:0] T_LAST   = ADDR_W'(TIMESTEP - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        L1_ACC   = 4'd1,
        L1_DRAIN = 4'd2,
        L1_WR    = 4'd3,
        L1_CLR   = 4'd4,
        L2_ACC   = 4'd5,
        L2_DRAIN = 4'd6,
        L2_WR    = 4'd7,
        L2_CLR   = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] k_r, k_s, j_r, j_s, t_r, t_s;

    // Next-state and counter update; en=0 holds everything in place.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        j_s     = j_r;
        t_s     = t_r;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = L1_ACC;
                        k_s     = ZERO_A;
                        j_s     = ZERO_A;
                        t_s     = ZERO_A;
                    end else begin
                        state_s = IDLE;
                    end
                end
                L1_ACC: begin
                    if (k_r == N1_LAST) begin
                        state_s = L1_DRAIN;
                        k_s     = ZERO_A;
                    end else begin
                        k_s = k_r + ONE_A;
                    end
                end
                L1_DRAIN: state_s = L1_WR;
                L1_WR:    state_s = L1_CLR;
                L1_CLR: begin
                    if (j_r == L1C_LAST) begin
                        state_s = L2_ACC;
                        j_s     = ZERO_A;
                    end else begin
                        state_s = L1_ACC;
                        j_s     = j_r + ONE_A;
                    end
                end
                L2_ACC: begin
                    if (k_r == N2_LAST) begin
                        state_s = L2_DRAIN;
                        k_s     = ZERO_A;
                    end else begin
                        k_s = k_r + ONE_A;
                    end
                end
                L2_DRAIN: state_s = L2_WR;
                L2_WR:    state_s = L2_CLR;
                L2_CLR: begin
                    if (j_r == L2C_LAST) begin
                        j_s = ZERO_A;
                        if (t_r == T_LAST) begin
                            state_s = DONE;
                            t_s     = ZERO_A;
                        end else begin
                            state_s = L1_ACC;
                            t_s     = t_r + ONE_A;
                        end
                    end else begin
                        state_s = L2_ACC;
                        j_s     = j_r + ONE_A;
                    end
                end
                DONE: state_s = IDLE;
                default: begin
                    state_s = IDLE;
                    k_s     = ZERO_A;
                    j_s     = ZERO_A;
                    t_s     = ZERO_A;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Outputs are decoded from the next state so the registered outputs line
    // up with the state they describe; strobes are squashed while stalled.
    logic first_t_s, l1_acc_s, l2_acc_s, in_l1_s, in_l2_s;
    assign first_t_s = (t_s == ZERO_A);
    assign l1_acc_s  = (state_s == L1_ACC);
    assign l2_acc_s  = (state_s == L2_ACC);
    assign in_l1_s   = (state_s == L1_ACC) || (state_s == L1_DRAIN) ||
                       (state_s == L1_WR)  || (state_s == L1_CLR);
    assign in_l2_s   = (state_s == L2_ACC) || (state_s == L2_DRAIN) ||
                       (state_s == L2_WR)  || (state_s == L2_CLR);

    logic acc_x_1_s, acc_h_1_s, wr_1_s, clr_1_s;
    logic acc_x_2_s, acc_h_2_s, wr_2_s, clr_2_s;
    logic [ADDR_W-1:0] addr_x1_s, w1_s, u1_s, b1_s, h1_s, c1_s, wa1_s;
    logic [ADDR_W-1:0] addr_x2_s, w2_s, u2_s, b2_s, h2_s, c2_s, wa2_s;

    assign acc_x_1_s = en && l1_acc_s && (k_s < L1I_A);
    assign acc_h_1_s = en && l1_acc_s && (k_s < L1C_A) && !first_t_s;
    assign wr_1_s    = en && (state_s == L1_WR);
    assign clr_1_s   = en && (state_s == L1_CLR);
    assign addr_x1_s = l1_acc_s ? (t_s * L1I_A + k_s) : ZERO_A;
    assign w1_s      = l1_acc_s ? (j_s * L1I_A + k_s) : ZERO_A;
    assign u1_s      = l1_acc_s ? (j_s * L1C_A + k_s) : ZERO_A;
    assign h1_s      = (l1_acc_s && !first_t_s) ? ((t_s - ONE_A) * L1C_A + k_s) : ZERO_A;
    assign b1_s      = in_l1_s ? j_s : ZERO_A;
    assign c1_s      = (in_l1_s && !first_t_s) ? ((t_s - ONE_A) * L1C_A + j_s) : ZERO_A;
    assign wa1_s     = in_l1_s ? (t_s * L1C_A + j_s) : ZERO_A;

    assign acc_x_2_s = en && l2_acc_s && (k_s < L1C_A);
    assign acc_h_2_s = en && l2_acc_s && (k_s < L2C_A) && !first_t_s;
    assign wr_2_s    = en && (state_s == L2_WR);
    assign clr_2_s   = en && (state_s == L2_CLR);
    assign addr_x2_s = l2_acc_s ? (t_s * L1C_A + k_s) : ZERO_A;
    assign w2_s      = l2_acc_s ? (j_s * L1C_A + k_s) : ZERO_A;
    assign u2_s      = l2_acc_s ? (j_s * L2C_A + k_s) : ZERO_A;
    assign h2_s      = (l2_acc_s && !first_t_s) ? ((t_s - ONE_A) * L2C_A + k_s) : ZERO_A;
    assign b2_s      = in_l2_s ? j_s : ZERO_A;
    assign c2_s      = (in_l2_s && !first_t_s) ? ((t_s - ONE_A) * L2C_A + j_s) : ZERO_A;
    assign wa2_s     = in_l2_s ? (t_s * L2C_A + j_s) : ZERO_A;

    // State, counters and every output register; reset clears all of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= ZERO_A;
            j_r         <= ZERO_A;
            t_r         <= ZERO_A;
            busy        <= 1'b0;
            done        <= 1'b0;
            t_idx       <= ZERO_A;
            cell_idx    <= ZERO_A;
            acc_x_1     <= 1'b0;
            acc_h_1     <= 1'b0;
            wr_h1       <= 1'b0;
            wr_c1       <= 1'b0;
            clr_1       <= 1'b0;
            addr_x1     <= ZERO_A;
            rd_addr_w_1 <= ZERO_A;
            rd_addr_u_1 <= ZERO_A;
            rd_addr_b_1 <= ZERO_A;
            rd_addr_h1  <= ZERO_A;
            rd_addr_c1  <= ZERO_A;
            wr_addr_h1  <= ZERO_A;
            wr_addr_c1  <= ZERO_A;
            acc_x_2     <= 1'b0;
            acc_h_2     <= 1'b0;
            wr_h2       <= 1'b0;
            wr_c2       <= 1'b0;
            clr_2       <= 1'b0;
            rd_addr_x2  <= ZERO_A;
            rd_addr_w_2 <= ZERO_A;
            rd_addr_u_2 <= ZERO_A;
            rd_addr_b_2 <= ZERO_A;
            rd_addr_h2  <= ZERO_A;
            rd_addr_c2  <= ZERO_A;
            wr_addr_h2  <= ZERO_A;
            wr_addr_c2  <= ZERO_A;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            j_r         <= j_s;
            t_r         <= t_s;
            busy        <= (state_s != IDLE);
            done        <= (state_s == DONE);
            t_idx       <= t_s;
            cell_idx    <= j_s;
            acc_x_1     <= acc_x_1_s;
            acc_h_1     <= acc_h_1_s;
            wr_h1       <= wr_1_s;
            wr_c1       <= wr_1_s;
            clr_1       <= clr_1_s;
            addr_x1     <= addr_x1_s;
            rd_addr_w_1 <= w1_s;
            rd_addr_u_1 <= u1_s;
            rd_addr_b_1 <= b1_s;
            rd_addr_h1  <= h1_s;
            rd_addr_c1  <= c1_s;
            wr_addr_h1  <= wa1_s;
            wr_addr_c1  <= wa1_s;
            acc_x_2     <= acc_x_2_s;
            acc_h_2     <= acc_h_2_s;
            wr_h2       <= wr_2_s;
            wr_c2       <= wr_2_s;
            clr_2       <= clr_2_s;
            rd_addr_x2  <= addr_x2_s;
            rd_addr_w_2 <= w2_s;
            rd_addr_u_2 <= u2_s;
            rd_addr_b_2 <= b2_s;
            rd_addr_h2  <= h2_s;
            rd_addr_c2  <= c2_s;
            wr_addr_h2  <= wa2_s;
            wr_addr_c2  <= wa2_s;
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl: a loop-nest model pushes the expected
// per-cycle outputs into a queue that is popped and compared every cycle.
module tb_lstm_seq_ctrl;

    localparam int AW = 12;
    localparam int TS = 2;
    localparam int I1 = 3;
    localparam int C1 = 2;
    localparam int C2 = 1;
    localparam int N1 = 3;
    localparam int N2 = 2;

    logic clk, rst, start, en;
    logic busy, done, acc_x_1, acc_h_1, wr_h1, wr_c1, clr_1;
    logic acc_x_2, acc_h_2, wr_h2, wr_c2, clr_2;
    logic [AW-1:0] t_idx, cell_idx;
    logic [AW-1:0] addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1, wr_addr_h1, wr_addr_c1;
    logic [AW-1:0] rd_addr_x2, rd_addr_w_2, rd_addr_u_2, rd_addr_b_2, rd_addr_h2, rd_addr_c2, wr_addr_h2, wr_addr_c2;

    lstm_seq_ctrl #(.ADDR_W(AW), .TIMESTEP(TS), .LAYR1_INPUT(I1), .LAYR1_CELL(C1), .LAYR2_CELL(C2)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .busy(busy), .done(done), .t_idx(t_idx), .cell_idx(cell_idx),
        .acc_x_1(acc_x_1), .acc_h_1(acc_h_1), .wr_h1(wr_h1), .wr_c1(wr_c1), .clr_1(clr_1),
        .addr_x1(addr_x1), .rd_addr_w_1(rd_addr_w_1), .rd_addr_u_1(rd_addr_u_1), .rd_addr_b_1(rd_addr_b_1),
        .rd_addr_h1(rd_addr_h1), .rd_addr_c1(rd_addr_c1), .wr_addr_h1(wr_addr_h1), .wr_addr_c1(wr_addr_c1),
        .acc_x_2(acc_x_2), .acc_h_2(acc_h_2), .wr_h2(wr_h2), .wr_c2(wr_c2), .clr_2(clr_2),
        .rd_addr_x2(rd_addr_x2), .rd_addr_w_2(rd_addr_w_2), .rd_addr_u_2(rd_addr_u_2), .rd_addr_b_2(rd_addr_b_2),
        .rd_addr_h2(rd_addr_h2), .rd_addr_c2(rd_addr_c2), .wr_addr_h2(wr_addr_h2), .wr_addr_c2(wr_addr_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] flags;
        int          ph;
        int          t, j, k;
        bit          acc, wr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   mc    = 0;
    int   dc;

    logic [11:0] obs_flags;
    assign obs_flags = {busy, done, acc_x_1, acc_h_1, wr_h1, wr_c1, clr_1,
                        acc_x_2, acc_h_2, wr_h2, wr_c2, clr_2};

    logic [12+18*AW-1:0] all_out;
    assign all_out = {obs_flags, t_idx, cell_idx,
                      addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1, wr_addr_h1, wr_addr_c1,
                      rd_addr_x2, rd_addr_w_2, rd_addr_u_2, rd_addr_b_2, rd_addr_h2, rd_addr_c2, wr_addr_h2, wr_addr_c2};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        tests++;
        assert (all_out === '0) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=0", tag, cyc, all_out);
        end
    endtask

    // Append one expected cycle; after model cycle sa, add sl frozen copies.
    task automatic add(input logic [11:0] f, input int ph, input int t, input int j, input int k,
                       input bit acc, input bit wr, input int sa, input int sl);
        exp_t e;
        e.flags = f; e.ph = ph; e.t = t; e.j = j; e.k = k; e.acc = acc; e.wr = wr;
        q.push_back(e);
        mc++;
        if (mc == sa) begin
            for (int i = 0; i < sl; i++) begin
                e.flags = f & 12'hC00;
                q.push_back(e);
            end
        end
    endtask

    task automatic build(input int sa, input int sl);
        q.delete();
        mc = 0;
        for (int t = 0; t < TS; t++) begin
            for (int j = 0; j < C1; j++) begin
                for (int k = 0; k < N1; k++)
                    add({2'b10, (k < I1), (k < C1 && t > 0), 8'h00}, 1, t, j, k, 1'b1, 1'b0, sa, sl);
                add(12'h800, 1, t, j, 0, 1'b0, 1'b0, sa, sl);
                add(12'h8C0, 1, t, j, 0, 1'b0, 1'b1, sa, sl);
                add(12'h820, 1, t, j, 0, 1'b0, 1'b0, sa, sl);
            end
            for (int j = 0; j < C2; j++) begin
                for (int k = 0; k < N2; k++)
                    add({2'b10, 5'b00000, (k < C1), (k < C2 && t > 0), 3'b000}, 2, t, j, k, 1'b1, 1'b0, sa, sl);
                add(12'h800, 2, t, j, 0, 1'b0, 1'b0, sa, sl);
                add(12'h806, 2, t, j, 0, 1'b0, 1'b1, sa, sl);
                add(12'h801, 2, t, j, 0, 1'b0, 1'b0, sa, sl);
            end
        end
        add(12'hC00, 0, 0, 0, 0, 1'b0, 1'b0, sa, sl);
        add(12'h000, 0, 0, 0, 0, 1'b0, 1'b0, sa, sl);
        add(12'h000, 0, 0, 0, 0, 1'b0, 1'b0, sa, sl);
    endtask

    // One clock; sample 1 time unit after the edge and check the head of the queue.
    task automatic step_check();
        exp_t e;
        int hp;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("flags", {20'd0, obs_flags}, {20'd0, e.flags});
            if (e.flags[11] && !e.flags[10]) begin
                chk("t_idx", t_idx, e.t);
                chk("cell_idx", cell_idx, e.j);
            end
            if (e.ph == 1) begin
                hp = (e.t == 0) ? 0 : (e.t - 1) * C1;
                chk("rd_addr_b_1", rd_addr_b_1, e.j);
                chk("rd_addr_c1", rd_addr_c1, (e.t == 0) ? 0 : hp + e.j);
                if (e.acc) begin
                    chk("addr_x1", addr_x1, e.t * I1 + e.k);
                    chk("rd_addr_w_1", rd_addr_w_1, e.j * I1 + e.k);
                    chk("rd_addr_u_1", rd_addr_u_1, e.j * C1 + e.k);
                    chk("rd_addr_h1", rd_addr_h1, (e.t == 0) ? 0 : hp + e.k);
                end
                if (e.wr) begin
                    chk("wr_addr_h1", wr_addr_h1, e.t * C1 + e.j);
                    chk("wr_addr_c1", wr_addr_c1, e.t * C1 + e.j);
                end
            end
            if (e.ph == 2) begin
                hp = (e.t == 0) ? 0 : (e.t - 1) * C2;
                chk("rd_addr_b_2", rd_addr_b_2, e.j);
                chk("rd_addr_c2", rd_addr_c2, (e.t == 0) ? 0 : hp + e.j);
                if (e.acc) begin
                    chk("rd_addr_x2", rd_addr_x2, e.t * C1 + e.k);
                    chk("rd_addr_w_2", rd_addr_w_2, e.j * C1 + e.k);
                    chk("rd_addr_u_2", rd_addr_u_2, e.j * C2 + e.k);
                    chk("rd_addr_h2", rd_addr_h2, (e.t == 0) ? 0 : hp + e.k);
                end
                if (e.wr) begin
                    chk("wr_addr_h2", wr_addr_h2, e.t * C2 + e.j);
                    chk("wr_addr_c2", wr_addr_c2, e.t * C2 + e.j);
                end
            end
        end
    endtask

    // Pulse start, then step until the expected trace is consumed (bounded).
    task automatic do_run(input int sa, input int sl, input int ign_at, input int abort_at, output int d);
        int n;
        n = 0;
        d = -1;
        start = 1'b1;
        while (q.size() > 0 && n < 200) begin
            step_check();
            n++;
            start = (n == ign_at) ? 1'b1 : 1'b0;
            en = (sl > 0 && n >= sa && n < sa + sl) ? 1'b0 : 1'b1;
            if (done === 1'b1 && d < 0) d = n;
            if (n == abort_at) break;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b1;
        step_check();
        step_check();
        chk_all_zero("reset_state");
        rst = 1'b0;
        step_check();
        step_check();
        chk_all_zero("idle_after_release");

        // Plain run with a start pulse injected mid-run that must be ignored.
        build(0, 0);
        do_run(0, 0, 20, -1, dc);
        chk("run_a_drained", q.size(), 0);
        chk("run_a_done_cycle", dc, 35);

        // Five stalled cycles inside L1_ACC push done out by exactly five.
        build(2, 5);
        do_run(2, 5, -1, -1, dc);
        chk("run_b_drained", q.size(), 0);
        chk("run_b_done_cycle", dc, 40);

        // Asynchronous reset while in L2_ACC, then no resume without start.
        build(0, 0);
        do_run(0, 0, -1, 13, dc);
        chk("run_c_in_l2_acc", {31'd0, acc_x_2}, 32'd1);
        q.delete();
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset_same_cycle");
        step_check();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_check();
            chk_all_zero("no_resume_after_reset");
        end

        // A fresh start after reset gives an unchanged full run.
        build(0, 0);
        do_run(0, 0, -1, -1, dc);
        chk("run_d_drained", q.size(), 0);
        chk("run_d_done_cycle", dc, 35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
